ysyx_22041071_pcgen: RTL and testbench
======================================

# ysyx_22041071_pcgen

Program-counter generation stage, directly upstream of instruction fetch. Holds the architectural fetch PC and presents it to fetch with a valid/ready handshake. Advances sequentially by 4 on each accepted PC and applies branch/jump and trap redirects with fixed priority. Also provides a halt state for simulation end and a fetch counter for difftest bookkeeping.

## Interface
Parameters:
- START_ADDR, 64'h8000_0000, reset PC (shared constant `START_ADDR`)
- ADDR_W, 64, PC width (matches `ysyx_22041071_ADDR_BUS`)

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- ready1  in  1  fetch stage can accept PC this cycle
- br_valid  in  1  branch/jump resolved taken, one-cycle pulse
- br_target  in  ADDR_W  branch/jump target
- trap_valid  in  1  trap/mret redirect, one-cycle pulse
- trap_target  in  ADDR_W  mtvec/mepc target
- halt_req  in  1  ebreak committed, one-cycle pulse
- PC1  out  ADDR_W  PC offered to fetch
- valid1  out  1  PC1 is valid
- flush  out  1  redirect applied this cycle; younger stages squash
- misalign  out  1  redirect target had bits[1:0] != 0 (one-cycle pulse)
- halted  out  1  generator stopped
- fetch_cnt  out  64  count of accepted PCs

## Operation
- FSM states: BOOT, RUN, HALT.
  - BOOT: entered on reset; valid1=0; unconditionally goes to RUN next cycle.
  - RUN: valid1=1; handles handshakes and redirects.
  - HALT: valid1=0, halted=1; exited only by reset.
- Handshake: accept = valid1 & ready1. On accept with no redirect: PC1 <= PC1 + 4, fetch_cnt <= fetch_cnt + 1.
- Without accept and without redirect: PC1 and valid1 held stable.
- Redirect priority: trap_valid > br_valid > sequential.
- Redirect in RUN, with or without ready1: PC1 <= {target[63:2], 2'b00}; flush=1 in the same cycle (combinational from the valid inputs).
  - Stability of the un-accepted PC1 is waived, since it is wrong-path.
  - If accept coincides with the redirect, fetch_cnt still increments.
- misalign = selected redirect valid & (target[1:0] != 0). The target is still applied after the low bits are cleared.
- halt_req in RUN moves to HALT next cycle. If it coincides with a redirect, halt wins; flush is still asserted.
- Redirects and handshakes in BOOT or HALT are ignored: flush=0, PC1 unchanged.
- PC arithmetic is modulo 2^64; FFFF_FFFF_FFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset values: PC1=START_ADDR, valid1=0, flush=0, misalign=0, halted=0, fetch_cnt=0, state=BOOT.
- The first valid1=1 appears on the first cycle after reset deasserts, with PC1=START_ADDR.
- Sequential throughput: one PC per cycle while ready1=1.
- Redirect latency: target visible on PC1 the cycle after the redirect pulse, with valid1=1.
- flush and misalign are combinational, valid in the redirect cycle only.
- Reset asserted mid-operation, including in HALT or during a redirect, overrides everything: all outputs return to reset values on the next edge.

## Structure
- Shared package/define file holds:
  - `START_ADDR`
  - `ysyx_22041071_ADDR_BUS`
  - state encodings: BOOT=2'd0, RUN=2'd1, HALT=2'd2
- Single module, no sub-module.
- Next-PC mux selection (trap/br/seq) is a combinational block inside the module.

## Test plan
- Reset then ready1=1 for 4 cycles -> PC1 = 8000_0000, 8000_0004, 8000_0008, 8000_000C; fetch_cnt=4.
- ready1=0 for 3 cycles at PC 8000_0008 -> PC1 and valid1 held; fetch_cnt unchanged.
- br_valid with br_target=8000_0100 and trap_valid with trap_target=8000_0200 in the same cycle -> flush=1; next PC1=8000_0200.
- br_valid with br_target=8000_0103 while ready1=0 -> misalign=1, flush=1; next PC1=8000_0100; fetch_cnt unchanged.
- halt_req coinciding with br_valid -> next state HALT; valid1=0, halted=1; later br_valid ignored with flush=0.
- Reset asserted 2 cycles into HALT -> valid1=0, PC1=8000_0000 the next cycle; valid1=1 the cycle after.

Source files
------------

// File: rtl/ysyx_22041071_pcgen_pkg.sv
// Shared constants and state encoding for the program-counter generator.
// Imported by the interface and the pcgen module.
package ysyx_22041071_pcgen_pkg;

  localparam int ysyx_22041071_ADDR_BUS = 64;
  localparam logic [63:0] START_ADDR = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pcgenState_t;

endpackage

// File: rtl/ysyx_22041071_pcgen_if.sv
// Bundle between the PC generator (master) and instruction fetch / control (slave).
// Carries the fetch handshake, redirect requests and status outputs.
interface ysyx_22041071_pcgen_if
  import ysyx_22041071_pcgen_pkg::*;
#(
  parameter int ADDR_W = ysyx_22041071_ADDR_BUS
);

  logic              ready1;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              trap_valid;
  logic [ADDR_W-1:0] trap_target;
  logic              halt_req;
  logic [ADDR_W-1:0] PC1;
  logic              valid1;
  logic              flush;
  logic              misalign;
  logic              halted;
  logic [63:0]       fetch_cnt;

  modport master (
    input  ready1, br_valid, br_target, trap_valid, trap_target, halt_req,
    output PC1, valid1, flush, misalign, halted, fetch_cnt
  );

  modport slave (
    output ready1, br_valid, br_target, trap_valid, trap_target, halt_req,
    input  PC1, valid1, flush, misalign, halted, fetch_cnt
  );

endinterface

// File: rtl/ysyx_22041071_pcgen.sv
// Fetch PC generator: sequential +4 stepping, trap/branch redirects with
// trap priority, a terminal HALT state and a count of accepted PCs.
module ysyx_22041071_pcgen #(
  parameter int                ADDR_W     = ysyx_22041071_pcgen_pkg::ysyx_22041071_ADDR_BUS,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(ysyx_22041071_pcgen_pkg::START_ADDR)
) (
  input  logic                   clk,
  input  logic                   reset,
  ysyx_22041071_pcgen_if.master  io_bus
);

  import ysyx_22041071_pcgen_pkg::*;

  pcgenState_t       r_state;
  pcgenState_t       w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_nextPc;
  logic [ADDR_W-1:0] w_target;
  logic [63:0]       r_fetchCnt;
  logic              w_inRun;
  logic              w_halted;
  logic              w_accept;
  logic              w_redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Halt takes precedence over any redirect arriving in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_inRun     = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      BOOT: begin
        w_nextState = RUN;
      end
      RUN: begin
        w_inRun = 1'b1;
        if (io_bus.halt_req) begin
          w_nextState = HALT;
        end
      end
      HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_nextState = BOOT;
      end
    endcase
  end

  always_comb begin
    w_accept   = w_inRun & io_bus.ready1;
    w_redirect = w_inRun & (io_bus.trap_valid | io_bus.br_valid);
    w_target   = io_bus.trap_valid ? io_bus.trap_target : io_bus.br_target;
    w_nextPc   = r_pc;
    if (w_redirect) begin
      w_nextPc = {w_target[ADDR_W-1:2], 2'b00};
    end else if (w_accept) begin
      w_nextPc = r_pc + ADDR_W'(4);
    end
  end

  // A redirect replaces the wrong-path PC, but an accept in the same cycle
  // still counts as a fetched PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= START_ADDR;
      r_fetchCnt <= 64'd0;
    end else begin
      r_pc <= w_nextPc;
      if (w_accept) begin
        r_fetchCnt <= r_fetchCnt + 64'd1;
      end
    end
  end

  assign io_bus.PC1       = r_pc;
  assign io_bus.valid1    = w_inRun;
  assign io_bus.halted    = w_halted;
  assign io_bus.flush     = w_redirect;
  assign io_bus.misalign  = w_redirect & (w_target[1:0] != 2'b00);
  assign io_bus.fetch_cnt = r_fetchCnt;

endmodule

// File: tb/tb_ysyx_22041071_pcgen.sv
// Self-checking bench for the PC generator: directed scenarios followed by
// random traffic, compared each cycle against a behavioural model.
module tb_ysyx_22041071_pcgen;

  logic clk;
  logic reset;

  ysyx_22041071_pcgen_if #(.ADDR_W(64)) bus ();

  ysyx_22041071_pcgen dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: where the fetch PC is, how many PCs were taken,
  // and whether we are in the post-reset bubble or stopped.
  logic [63:0] mPc;
  logic [63:0] mCnt;
  bit          mBoot;
  bit          mHalt;

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expFlush, input logic expMis);
    bit running;
    running = !mBoot && !mHalt;
    checkBit({tag, ".valid1"}, bus.valid1, running);
    checkBit({tag, ".halted"}, bus.halted, mHalt);
    checkBit({tag, ".flush"}, bus.flush, expFlush);
    checkBit({tag, ".misalign"}, bus.misalign, expMis);
    checkWord({tag, ".fetch_cnt"}, bus.fetch_cnt, mCnt);
    if (!mHalt) checkWord({tag, ".PC1"}, bus.PC1, mPc);
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic applyStimulus(input string tag, input logic rst, input logic rdy,
                               input logic brv, input logic [63:0] bt,
                               input logic trv, input logic [63:0] tt,
                               input logic hr);
    bit          running;
    logic        expFlush;
    logic        expMis;
    logic [63:0] tgt;
    reset           = rst;
    bus.ready1      = rdy;
    bus.br_valid    = brv;
    bus.br_target   = bt;
    bus.trap_valid  = trv;
    bus.trap_target = tt;
    bus.halt_req    = hr;
    running  = !mBoot && !mHalt;
    tgt      = trv ? tt : bt;
    expFlush = running && (trv || brv);
    expMis   = expFlush && (tgt % 4 != 0);
    #2;
    checkOutput(tag, expFlush, expMis);
    @(posedge clk);
    if (rst) begin
      mPc   = 64'h8000_0000;
      mCnt  = 0;
      mBoot = 1;
      mHalt = 0;
    end else if (mBoot) begin
      mBoot = 0;
    end else if (running) begin
      if (rdy) mCnt = mCnt + 1;
      if (expFlush) mPc = tgt - (tgt % 4);
      else if (rdy) mPc = mPc + 4;
      if (hr) mHalt = 1;
    end
    #1;
  endtask

  task automatic idle(input string tag, input logic rdy);
    applyStimulus(tag, 1'b0, rdy, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    logic [63:0] rbt;
    logic [63:0] rtt;
    logic        rrst, rrdy, rbrv, rtrv, rhr;

    reset           = 1'b1;
    bus.ready1      = 1'b0;
    bus.br_valid    = 1'b0;
    bus.br_target   = '0;
    bus.trap_valid  = 1'b0;
    bus.trap_target = '0;
    bus.halt_req    = 1'b0;
    mPc = 64'h8000_0000; mCnt = 0; mBoot = 1; mHalt = 0;
    @(posedge clk);
    #1;

    applyStimulus("reset", 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    checkWord("resetPc", bus.PC1, 64'h8000_0000);
    // BOOT bubble: handshake and redirects are ignored.
    applyStimulus("boot", 1'b0, 1'b1, 1'b1, 64'h8000_0400, 1'b0, 64'h0, 1'b0);

    idle("seq0", 1'b1);
    idle("seq1", 1'b1);
    checkWord("seqAt8", bus.PC1, 64'h8000_0008);
    for (int i = 0; i < 3; i++) idle("stall", 1'b0);
    checkWord("stallCnt", bus.fetch_cnt, 64'd2);
    idle("seq2", 1'b1);
    idle("seq3", 1'b1);
    checkWord("seqCnt4", bus.fetch_cnt, 64'd4);
    checkWord("seqAt10", bus.PC1, 64'h8000_0010);

    applyStimulus("trapOverBr", 1'b0, 1'b1, 1'b1, 64'h8000_0100, 1'b1, 64'h8000_0200, 1'b0);
    checkWord("trapPc", bus.PC1, 64'h8000_0200);
    checkBit("trapValid", bus.valid1, 1'b1);

    applyStimulus("misalignBr", 1'b0, 1'b0, 1'b1, 64'h8000_0103, 1'b0, 64'h0, 1'b0);
    checkWord("misalignPc", bus.PC1, 64'h8000_0100);
    checkWord("misalignCnt", bus.fetch_cnt, 64'd5);

    applyStimulus("wrapBr", 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0, 1'b0);
    idle("wrapA", 1'b1);
    checkWord("wrapPc", bus.PC1, 64'h0);
    idle("wrapB", 1'b1);

    applyStimulus("haltBr", 1'b0, 1'b1, 1'b1, 64'h8000_0800, 1'b0, 64'h0, 1'b1);
    checkBit("haltedNow", bus.halted, 1'b1);
    applyStimulus("haltIgnBr", 1'b0, 1'b1, 1'b1, 64'h8000_0900, 1'b1, 64'h8000_0a00, 1'b0);
    applyStimulus("haltReset", 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    checkWord("haltResetPc", bus.PC1, 64'h8000_0000);
    checkBit("haltResetValid", bus.valid1, 1'b0);
    idle("postReset", 1'b1);
    checkBit("postResetValid", bus.valid1, 1'b1);

    // Reset arriving together with a redirect.
    applyStimulus("resetRedir", 1'b1, 1'b1, 1'b1, 64'h1234_5678, 1'b1, 64'h9abc_def0, 1'b0);
    checkWord("resetRedirPc", bus.PC1, 64'h8000_0000);

    for (int i = 0; i < 600; i++) begin
      rrst = ($urandom_range(59) == 0);
      rrdy = ($urandom_range(3) != 0);
      rbrv = ($urandom_range(5) == 0);
      rtrv = ($urandom_range(9) == 0);
      rhr  = ($urandom_range(39) == 0);
      rbt  = {$urandom, $urandom};
      rtt  = {$urandom, $urandom};
      if ($urandom_range(7) == 0) rbt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      applyStimulus("rand", rrst, rrdy, rbrv, rbt, rtrv, rtt, rhr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout obs=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
